fifo_wr_packer: RTL and testbench
=================================

# fifo_wr_packer

Write-side source adapter for the 65-bit async FIFO, running entirely in the `wr_clk` domain. It accepts a 32-bit valid/ready stream with a `last` flag and packs pairs of beats into one 65-bit FIFO word, laid out as {last, hi, lo}. It issues `wr_fire` only when the FIFO reports not-full, and it back-pressures the upstream stream.

## Interface
- `IN_W`, default 32: input beat width. The FIFO word width is 2*IN_W+1.
- `PAD_WORD`, default 0: value (IN_W bits) placed in the hi half when a packet ends on an odd beat.
- `wr_clk`, in, 1: write-domain clock. All logic is on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `s_valid`, in, 1: upstream beat valid.
- `s_ready`, out, 1: upstream beat accepted when `s_valid && s_ready`.
- `s_data`, in, IN_W: upstream beat data.
- `s_last`, in, 1: final beat of a packet.
- `fifo_full`, in, 1: full flag from the FIFO write side.
- `wr_fire`, out, 1: FIFO write strobe.
- `wr_data`, out, 2*IN_W+1: FIFO write word, laid out as {last, hi[IN_W-1:0], lo[IN_W-1:0]}.
- `words_written`, out, 32: count of FIFO writes. Statistics only.
- `stall_cycles`, out, 32: count of cycles blocked by `fifo_full`. Statistics only.

## Operation
- Internal state:
  - `lo_reg` (IN_W bits) with `lo_valid`.
  - Output register `out_reg` (2*IN_W+1 bits) with `out_valid`.
  - Pack FSM with two states: EMPTY (`lo_valid=0`) and HALF (`lo_valid=1`).
- Combinational outputs:
  - `wr_fire = out_valid && !fifo_full`.
  - `wr_data = out_reg`.
  - `s_ready = !out_valid || wr_fire`.
- Accepted beat in EMPTY:
  - `s_last=0`: `lo_reg <= s_data`, go to HALF. `out_reg` is untouched.
  - `s_last=1`: `out_reg <= {1'b1, PAD_WORD, s_data}`, `out_valid <= 1`, stay in EMPTY.
- Accepted beat in HALF: `out_reg <= {s_last, s_data, lo_reg}`, `out_valid <= 1`, go to EMPTY. This happens regardless of `s_last`.
- `wr_fire` without a new load in the same cycle: `out_valid <= 0`.
- `wr_fire` and a new load in the same edge: the load wins. `out_valid` stays 1 and `out_reg` takes the new word. No bubble and no loss.
- When the accepted beat only fills `lo_reg` (EMPTY with `s_last=0`), `out_valid` follows `wr_fire` alone.
- `fifo_full` held: `out_reg` is frozen.
  - `s_ready` is 0 while `out_valid` is set.
  - A beat that would only fill `lo_reg` still waits; `s_ready` is not split per state.
- `s_valid` may drop at any cycle. No state changes without an accepted beat or `wr_fire`.
- Reset, including reset mid-packet:
  - `lo_valid=0`, `out_valid=0`, FSM in EMPTY, counters 0.
  - `lo_reg` and `out_reg` are cleared to 0.
  - Any partial pair is discarded.
- Reset values of outputs: `s_ready=1`, `wr_fire=0`, `wr_data=0`, `words_written=0`, `stall_cycles=0`.

## Timing
- Latency: a pair-completing beat accepted at edge N asserts `wr_fire` in the cycle after edge N, provided `fifo_full=0`. The FIFO captures the word at edge N+1.
- Throughput: 1 input beat per cycle sustained. At most 1 FIFO write per 2 input beats, except for odd-length packets.
- `wr_fire` is never asserted while `fifo_full=1`. `wr_data` is stable whenever `out_valid=1` and no load occurs.
- No combinational path from `s_valid` to `s_ready`. There is a combinational path from `fifo_full` to `s_ready` and to `wr_fire`.

## Configuration
- `FIFO_WR_PACKER_STATS_EN` defined:
  - `words_written` increments on every `wr_fire`.
  - `stall_cycles` increments on every cycle with `out_valid && fifo_full`.
  - Both counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- Not defined: both ports are tied to 0 and no counter flops are built. The port list is unchanged.

## Test plan
- Reset, then beats 0x11111111 (last=0) and 0x22222222 (last=1) on consecutive cycles with `fifo_full=0` -> one `wr_fire` one cycle after the second beat, `wr_data=0x1_22222222_11111111`.
- Single beat 0xAAAAAAAA with last=1, `PAD_WORD=0xDEADBEEF` -> `wr_data=0x1_DEADBEEF_AAAAAAAA`, exactly one `wr_fire`.
- Continuous 8-beat packet (`s_valid` held, last on beat 8) -> 4 `wr_fire` pulses in alternate cycles, last bit set only on the 4th, `s_ready` constantly 1.
- `fifo_full=1` for 10 cycles while a completed pair is pending, then released -> `wr_fire=0` and `wr_data` frozen throughout, `s_ready=0`, then one write, and `stall_cycles=10` with the macro defined.
- `rst` pulsed while in HALF holding 0x55555555, then beats 0x1 and 0x2 (last=1) -> only `wr_data=0x1_00000002_00000001` is written, and 0x55555555 never appears.
- Back-to-back pairs while the FIFO drains every cycle -> `out_valid` is reloaded on the same edge as `wr_fire`, no word is lost or duplicated, and `words_written` equals the number of pairs.

Source files
------------

// File: rtl/fifo_wr_packer.sv
// Purpose: packs pairs of IN_W-bit stream beats into {last, hi, lo} words for the async FIFO write port.
// Latency: a pair-completing (or odd-ending) beat accepted at edge N presents wr_fire in the following cycle.
// Backpressure: s_ready drops while a packed word is held and the FIFO is full; optional stats under FIFO_WR_PACKER_STATS_EN.
module fifo_wr_packer #(
    parameter int              IN_W     = 32,
    parameter logic [IN_W-1:0] PAD_WORD = '0
) (
    input  logic                wr_clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [IN_W-1:0]     s_data,
    input  logic                s_last,
    input  logic                fifo_full,
    output logic                wr_fire,
    output logic [2*IN_W:0]     wr_data,
    output logic [31:0]         words_written,
    output logic [31:0]         stall_cycles
);

    localparam int OUT_W = 2 * IN_W + 1;

    // EMPTY: no low half held; HALF: lo_q holds the first beat of a pair.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IN_W-1:0]    lo_q, lo_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               out_vld_q, out_vld_d;
    logic               beat_acc;
    logic               load;

    // The held word leaves when the FIFO has room; a new beat is taken whenever
    // the output slot is empty or is being vacated this cycle.
    assign wr_fire  = out_vld_q && !fifo_full;
    assign wr_data  = out_q;
    assign s_ready  = !out_vld_q || wr_fire;
    assign beat_acc = s_valid && s_ready;

    // Pack FSM next-state: decide whether the accepted beat fills lo or completes a word.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        out_d   = out_q;
        load    = 1'b0;
        if (beat_acc) begin
            case (state_q)
                ST_EMPTY: begin
                    if (s_last) begin
                        // Odd-length packet end: pad the hi half.
                        out_d = {1'b1, PAD_WORD, s_data};
                        load  = 1'b1;
                    end else begin
                        lo_d    = s_data;
                        state_d = ST_HALF;
                    end
                end
                ST_HALF: begin
                    out_d   = {s_last, s_data, lo_q};
                    load    = 1'b1;
                    state_d = ST_EMPTY;
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        // A load on the same edge as a write keeps the slot full with the new word.
        if (load) begin
            out_vld_d = 1'b1;
        end else if (wr_fire) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end
    end

    // Pack state and data registers; reset discards any partial pair.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            lo_q      <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

`ifdef FIFO_WR_PACKER_STATS_EN
    logic [31:0] words_q;
    logic [31:0] stall_q;

    // Statistics: FIFO writes and cycles a held word was blocked by full; both wrap.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            if (wr_fire) begin
                words_q <= words_q + 32'd1;
            end
            if (out_vld_q && fifo_full) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign words_written = words_q;
    assign stall_cycles  = stall_q;
`else
    assign words_written = 32'd0;
    assign stall_cycles  = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_packer.sv
module tb_fifo_wr_packer;

`ifdef FIFO_WR_PACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        wr_clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        fifo_full;
    logic        wr_fire;
    logic [64:0] wr_data;
    logic [31:0] words_written;
    logic [31:0] stall_cycles;

    int tests = 0;
    int fails = 0;
    int fire_cnt = 0;
    int b2b_cnt = 0;
    int not_ready_seen = 0;
    bit prev_fire = 1'b0;
    logic [64:0] sb[$];

    fifo_wr_packer #(.IN_W(32), .PAD_WORD(32'hDEADBEEF)) dut (
        .wr_clk        (wr_clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .fifo_full     (fifo_full),
        .wr_fire       (wr_fire),
        .wr_data       (wr_data),
        .words_written (words_written),
        .stall_cycles  (stall_cycles)
    );

    always #5 wr_clk = ~wr_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Monitor: every FIFO write is popped from the scoreboard and compared.
    initial begin
        forever begin
            @(negedge wr_clk);
            if (!rst && wr_fire) begin
                fire_cnt++;
                if (prev_fire) b2b_cnt++;
                chk("fire_while_full", {64'd0, fifo_full}, 65'd0);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got %h required no write", wr_data);
                end else begin
                    chk("wr_data", wr_data, sb.pop_front());
                end
            end
            prev_fire = !rst && wr_fire;
        end
    end

    task automatic expect_word(input logic last, input logic [31:0] hi, input logic [31:0] lo);
        sb.push_back({last, hi, lo});
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        forever begin
            @(negedge wr_clk);
            if (s_ready) begin
                @(posedge wr_clk);
                #1;
                break;
            end
            not_ready_seen++;
            n++;
            if (n > 100) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: got s_ready=0 for %0d cycles required acceptance", n);
                break;
            end
        end
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_data  = 32'h0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge wr_clk);
            #1;
            n++;
        end
        chk("drain_queue_empty", 65'(sb.size()), 65'd0);
        repeat (2) @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge wr_clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int f0;
        rst       = 1'b1;
        fifo_full = 1'b0;
        idle();
        repeat (3) @(posedge wr_clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge wr_clk);
        chk("rst_s_ready", {64'd0, s_ready}, 65'd1);
        chk("rst_wr_fire", {64'd0, wr_fire}, 65'd0);
        chk("rst_wr_data", wr_data, 65'd0);
        chk("rst_words", {33'd0, words_written}, 65'd0);
        chk("rst_stalls", {33'd0, stall_cycles}, 65'd0);
        @(posedge wr_clk);
        #1;

        // Basic pair, fire one cycle after the completing beat
        expect_word(1'b1, 32'h22222222, 32'h11111111);
        send(32'h11111111, 1'b0);
        send(32'h22222222, 1'b1);
        idle();
        @(negedge wr_clk);
        chk("pair_fire_latency", {64'd0, wr_fire}, 65'd1);
        wait_drain();

        // Single-beat packet gets padded hi half
        f0 = fire_cnt;
        expect_word(1'b1, 32'hDEADBEEF, 32'hAAAAAAAA);
        send(32'hAAAAAAAA, 1'b1);
        idle();
        wait_drain();
        chk("single_fire_count", 65'(fire_cnt - f0), 65'd1);

        // Continuous 8-beat packet: 4 writes in alternate cycles, s_ready always high
        f0 = fire_cnt;
        b2b_cnt = 0;
        not_ready_seen = 0;
        expect_word(1'b0, 32'h00000002, 32'h00000001);
        expect_word(1'b0, 32'h00000004, 32'h00000003);
        expect_word(1'b0, 32'h00000006, 32'h00000005);
        expect_word(1'b1, 32'h00000008, 32'h00000007);
        for (int i = 1; i <= 8; i++) send(32'(i), i == 8);
        idle();
        wait_drain();
        chk("burst8_fire_count", 65'(fire_cnt - f0), 65'd4);
        chk("burst8_no_b2b", 65'(b2b_cnt), 65'd0);
        chk("burst8_ready_high", 65'(not_ready_seen), 65'd0);

        // FIFO full for 10 cycles while a pair is pending
        fifo_full = 1'b1;
        expect_word(1'b1, 32'h44444444, 32'h33333333);
        send(32'h33333333, 1'b0);
        send(32'h44444444, 1'b1);
        idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge wr_clk);
            chk("full_no_fire", {64'd0, wr_fire}, 65'd0);
            chk("full_frozen", wr_data, 65'h1_44444444_33333333);
            chk("full_not_ready", {64'd0, s_ready}, 65'd0);
            @(posedge wr_clk);
            #1;
        end
        chk("stall_cycles", {33'd0, stall_cycles}, STATS ? 65'd10 : 65'd0);
        fifo_full = 1'b0;
        @(negedge wr_clk);
        chk("full_release_fire", {64'd0, wr_fire}, 65'd1);
        wait_drain();

        // Reset mid-packet discards the held low half
        send(32'h55555555, 1'b0);
        idle();
        do_reset();
        @(negedge wr_clk);
        chk("midrst_wr_data", wr_data, 65'd0);
        chk("midrst_s_ready", {64'd0, s_ready}, 65'd1);
        chk("midrst_words", {33'd0, words_written}, 65'd0);
        @(posedge wr_clk);
        #1;
        expect_word(1'b1, 32'h00000002, 32'h00000001);
        send(32'h00000001, 1'b0);
        send(32'h00000002, 1'b1);
        idle();
        wait_drain();

        // Back-to-back pairs then single-beat packets: same-edge reload on drain
        do_reset();
        f0 = fire_cnt;
        b2b_cnt = 0;
        not_ready_seen = 0;
        for (int i = 0; i < 4; i++) expect_word(1'b1, 32'h200 + 32'(i), 32'h100 + 32'(i));
        for (int i = 0; i < 3; i++) expect_word(1'b1, 32'hDEADBEEF, 32'hC0000000 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            send(32'h100 + 32'(i), 1'b0);
            send(32'h200 + 32'(i), 1'b1);
        end
        for (int i = 0; i < 3; i++) send(32'hC0000000 + 32'(i), 1'b1);
        idle();
        wait_drain();
        chk("b2b_fire_count", 65'(fire_cnt - f0), 65'd7);
        chk("b2b_reload_count", 65'(b2b_cnt), 65'd3);
        chk("b2b_ready_high", 65'(not_ready_seen), 65'd0);
        chk("b2b_words_written", {33'd0, words_written}, STATS ? 65'd7 : 65'd0);
        chk("b2b_no_stalls", {33'd0, stall_cycles}, 65'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
